// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared fetch/decode types and constants.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [15:0] c_nop_instr = 16'hB800;

  localparam logic [1:0] c_class_00 = 2'b00;
  localparam logic [1:0] c_class_01 = 2'b01;
  localparam logic [1:0] c_class_10 = 2'b10;
  localparam logic [1:0] c_class_11 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_buf.sv
`default_nettype none
// ============================================================================
// Module   : instr_buf
// Brief    : Synchronous FIFO of fetched {instr,pc} entries with flush.
// Revision : 1.0 - initial release
// ============================================================================
module instr_buf
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_wr_data,
  output fetch_entry_t           o_rd_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int c_aw = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (c_aw+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      r_count <= r_count + (c_aw+1)'(w_do_push) - (c_aw+1)'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetch stage: PC, single-outstanding imem reads, instruction FIFO.
//            Optional perf counters enabled by macro IFETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [15:0] NOP_INSTR = c_nop_instr
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int c_cw = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [15:0]     r_fetch_pc;
  logic [15:0]     w_fetch_pc_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_buf_full;
  logic            w_buf_empty;
  logic [c_cw-1:0] w_count;
  logic            w_credit_now;
  logic            w_credit_after_push;
  fetch_entry_t    w_head;
  fetch_entry_t    w_wr_entry;

  // A redirect cancels any pop in the same cycle.
  assign w_pop = ~w_buf_empty & instr_ready & ~redirect_valid;

  assign w_credit_now        = ~w_buf_full | w_pop;
  assign w_credit_after_push = (w_count + c_cw'(1'b1) - c_cw'(w_pop)) < c_cw'(BUF_DEPTH);

  // fetch_pc already advanced on grant, so the returning word belongs to fetch_pc-1.
  assign w_wr_entry.instr = imem_rdata;
  assign w_wr_entry.pc    = r_fetch_pc - 16'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect_valid) begin
          w_fetch_pc_nxt = redirect_pc;
          w_state_nxt    = REQ;
        end else if (w_credit_now) begin
          w_state_nxt    = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          w_fetch_pc_nxt = redirect_pc;
          w_state_nxt    = imem_gnt ? DROP : REQ;
        end else if (imem_gnt) begin
          w_fetch_pc_nxt = r_fetch_pc + 16'd1;
          w_state_nxt    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          w_fetch_pc_nxt = redirect_pc;
          w_state_nxt    = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          w_push      = 1'b1;
          w_state_nxt = w_credit_after_push ? REQ : IDLE;
        end
      end
      DROP: begin
        if (redirect_valid) w_fetch_pc_nxt = redirect_pc;
        if (imem_rvalid)    w_state_nxt    = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  instr_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (redirect_valid),
    .i_wr_data (w_wr_entry),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_buf_full),
    .o_empty   (w_buf_empty)
  );

  assign imem_req    = (r_state == REQ);
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = ~w_buf_empty;
  assign instr       = w_buf_empty ? NOP_INSTR : w_head.instr;
  assign instr_pc    = w_buf_empty ? 16'h0000  : w_head.pc;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != '1))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (instr_valid && !instr_ready && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Randomized self-checking bench for instr_fetch with memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          DEPTH    = 2;
  localparam logic [15:0] NOP      = 16'hB800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  int gnt_pct, ready_pct, lat_min, lat_max;
  int unsigned cyc = 0;

  // memory side: at most one read in flight
  logic        mem_busy;
  logic [15:0] mem_addr;
  int unsigned mem_due;

  // expected view: decode sees a contiguous PC stream restarted by redirects
  logic [15:0] exp_pc, exp_fetch;
  logic        prev_hold, prev_redir, prev_redir_free;
  logic [15:0] prev_addr, prev_tgt;
  int unsigned pops, stalls;

  logic        s_req, s_valid, s_gnt, s_pop;
  logic [15:0] s_addr, s_instr, s_pc;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic model_reset();
    mem_busy        = 1'b0;
    mem_addr        = 16'h0;
    mem_due         = 0;
    exp_pc          = RESET_PC;
    exp_fetch       = RESET_PC;
    prev_hold       = 1'b0;
    prev_redir      = 1'b0;
    prev_redir_free = 1'b0;
    prev_addr       = 16'h0;
    prev_tgt        = 16'h0;
    pops            = 0;
    stalls          = 0;
  endtask

  task automatic drive_idle();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 16'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    instr_ready    = 1'b0;
  endtask

  // One clock: check outputs against the expected stream, drive inputs, advance model.
  task automatic cycle(input logic redir, input logic [15:0] tgt);
    logic rv, g, rdy, free;
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instr;  s_pc = instr_pc;

    if (prev_hold) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
        errors++;
        $display("FAIL addr_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, prev_addr);
      end
    end
    if (prev_redir_free) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== prev_tgt) begin
        errors++;
        $display("FAIL redirect_latency: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, prev_tgt);
      end
    end
    if (prev_redir) begin
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL redirect_flush: instr_valid=%b, required 0", instr_valid);
      end
    end
    if (imem_req === 1'b1) begin
      checks++;
      if (imem_addr !== exp_fetch) begin
        errors++;
        $display("FAIL fetch_addr: addr=%h, required %h", imem_addr, exp_fetch);
      end
      checks++;
      if (mem_busy) begin
        errors++;
        $display("FAIL one_outstanding: req=1 with read to %h pending, required req=0", mem_addr);
      end
    end
    if (instr_valid === 1'b1) begin
      checks++;
      if (instr_pc !== exp_pc || instr !== mem_fn(exp_pc)) begin
        errors++;
        $display("FAIL stream: pc=%h instr=%h, required pc=%h instr=%h", instr_pc, instr, exp_pc, mem_fn(exp_pc));
      end
    end else begin
      checks++;
      if (instr_valid !== 1'b0 || instr !== NOP) begin
        errors++;
        $display("FAIL empty_nop: valid=%b instr=%h, required valid=0 instr=%h", instr_valid, instr, NOP);
      end
    end

    rv  = mem_busy && (cyc >= mem_due);
    g   = (imem_req === 1'b1) && ($urandom_range(99) < gnt_pct);
    rdy = ($urandom_range(99) < ready_pct);
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_fn(mem_addr) : 16'($urandom);
    imem_gnt       = g;
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;

    free  = !((mem_busy && !rv) || g);
    s_gnt = g;
    s_pop = (instr_valid === 1'b1) && rdy && !redir;
    if (rv) mem_busy = 1'b0;
    if (g) begin
      mem_busy  = 1'b1;
      mem_addr  = imem_addr;
      mem_due   = cyc + $urandom_range(lat_max, lat_min);
      exp_fetch = imem_addr + 16'd1;
    end
    if (redir) begin
      exp_fetch = tgt;
      exp_pc    = tgt;
    end else if (s_pop) begin
      exp_pc = exp_pc + 16'd1;
    end
    if (s_pop) pops++;
    if ((instr_valid === 1'b1) && !rdy) stalls++;
    prev_hold       = (imem_req === 1'b1) && !g && !redir;
    prev_addr       = imem_addr;
    prev_redir      = redir;
    prev_redir_free = redir && free;
    prev_tgt        = tgt;
    cyc++;
  endtask

  task automatic set_mode(input int g, input int r, input int lmin, input int lmax);
    gnt_pct = g; ready_pct = r; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic test_reset();
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b valid=%b instr=%h pc=%h, required 0 0 %h 0000",
               imem_req, instr_valid, instr, instr_pc, NOP);
    end
`ifdef IFETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: fetched=%0d stall=%0d, required 0 0", perf_fetched, perf_stall);
    end
`endif
    rst_n = 1'b1;
    set_mode(0, 100, 1, 1);
    cycle(1'b0, 16'h0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h, required 1 %h", s_req, s_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] ga [3];
    logic [15:0] pp [3];
    int ng = 0, np = 0, first_g = -1, first_v = -1;
    set_mode(100, 100, 1, 1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 16'h0);
      if (s_gnt && ng < 3) begin
        ga[ng] = s_addr;
        if (ng == 0) first_g = i;
        ng++;
      end
      if (s_valid && first_v < 0) first_v = i;
      if (s_pop && np < 3) begin
        pp[np] = s_pc;
        np++;
      end
    end
    checks++;
    if (ng != 3 || np != 3) begin
      errors++;
      $display("FAIL seq_counts: grants=%0d pops=%0d, required 3 3", ng, np);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ga[k] !== RESET_PC + 16'(k) || pp[k] !== RESET_PC + 16'(k)) begin
          errors++;
          $display("FAIL seq_order[%0d]: addr=%h pc=%h, required %h", k, ga[k], pp[k], RESET_PC + 16'(k));
        end
      end
    end
    checks++;
    if (first_v - first_g != 2) begin
      errors++;
      $display("FAIL seq_latency: valid after %0d cycles, required 2", first_v - first_g);
    end
  endtask

  task automatic test_stall();
    logic [15:0] held = 16'h0;
    logic        req5 = 1'b1;
    int n = 0;
    set_mode(100, 0, 1, 1);
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, 16'h0);
      if (i == 5) begin
        held = s_instr;
        req5 = s_req;
      end
    end
    checks++;
    if (req5 !== 1'b0 || s_req !== 1'b0 || s_valid !== 1'b1 || s_instr !== held) begin
      errors++;
      $display("FAIL stall_hold: req=%b/%b valid=%b instr=%h, required req=0/0 valid=1 instr=%h",
               req5, s_req, s_valid, s_instr, held);
    end
    set_mode(0, 100, 1, 1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 16'h0);
      if (s_pop) n++;
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL stall_depth: drained=%0d, required %0d", n, DEPTH);
    end
    set_mode(100, 100, 1, 1);
    repeat (10) cycle(1'b0, 16'h0);
  endtask

  task automatic test_redirect_wait();
    logic found = 1'b0;
    set_mode(100, 100, 3, 3);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 16'h0);
      if (s_gnt) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir_wait_grant: no grant in 20 cycles, required one");
    end
    cycle(1'b1, 16'h0040);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 16'h0);
      if (s_valid) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || s_pc !== 16'h0040 || s_instr !== mem_fn(16'h0040)) begin
      errors++;
      $display("FAIL redir_wait_target: found=%b pc=%h instr=%h, required pc=0040 instr=%h",
               found, s_pc, s_instr, mem_fn(16'h0040));
    end
    repeat (6) cycle(1'b0, 16'h0);
  endtask

  task automatic test_gnt_hold();
    logic [15:0] a0;
    set_mode(0, 100, 1, 1);
    repeat (6) cycle(1'b0, 16'h0);
    a0 = s_addr;
    checks++;
    if (s_req !== 1'b1) begin
      errors++;
      $display("FAIL gnt_hold_req: req=%b, required 1", s_req);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 16'h0);
      checks++;
      if (s_req !== 1'b1 || s_addr !== a0) begin
        errors++;
        $display("FAIL gnt_hold_stable: req=%b addr=%h, required 1 %h", s_req, s_addr, a0);
      end
    end
    cycle(1'b1, 16'h1234);
    cycle(1'b0, 16'h0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 16'h1234) begin
      errors++;
      $display("FAIL gnt_hold_redirect: req=%b addr=%h, required 1 1234", s_req, s_addr);
    end
    set_mode(100, 100, 1, 1);
    repeat (8) cycle(1'b0, 16'h0);
  endtask

  task automatic test_wrap();
    logic [15:0] ga [2];
    logic [15:0] pp [2];
    int ng = 0, np = 0;
    set_mode(100, 100, 1, 1);
    cycle(1'b1, 16'hFFFF);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 16'h0);
      if (s_gnt && ng < 2) begin ga[ng] = s_addr; ng++; end
      if (s_pop && np < 2) begin pp[np] = s_pc; np++; end
    end
    checks++;
    if (ng != 2 || np != 2 || ga[0] !== 16'hFFFF || ga[1] !== 16'h0000 ||
        pp[0] !== 16'hFFFF || pp[1] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap: grants=%0d pops=%0d addr=%h,%h pc=%h,%h, required ffff,0000",
               ng, np, ga[0], ga[1], pp[0], pp[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    set_mode(100, 100, 5, 5);
    repeat (4) cycle(1'b0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 16'h0);
      if (s_gnt) break;
    end
    cycle(1'b0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: req=%b valid=%b instr=%h pc=%h, required 0 0 %h 0000",
               imem_req, instr_valid, instr, instr_pc, NOP);
    end
`ifdef IFETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_perf: fetched=%0d stall=%0d, required 0 0", perf_fetched, perf_stall);
    end
`endif
    drive_idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_mode(100, 100, 1, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'h0);
      if (s_gnt) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || s_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_mid_restart: granted=%b addr=%h, required 1 %h", found, s_addr, RESET_PC);
    end
    repeat (6) cycle(1'b0, 16'h0);
  endtask

  task automatic test_random();
    int unsigned p0 = pops;
    logic [15:0] tgt;
    set_mode(70, 70, 1, 4);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 4) begin
        tgt = ($urandom_range(3) == 0) ? 16'hFFFE + 16'($urandom_range(1)) : 16'($urandom);
        cycle(1'b1, tgt);
      end else begin
        cycle(1'b0, 16'h0);
      end
    end
    checks++;
    if (pops - p0 < 100) begin
      errors++;
      $display("FAIL random_progress: popped=%0d, required >=100", pops - p0);
    end
  endtask

`ifdef IFETCH_PERF_CNT_EN
  task automatic test_perf();
    @(negedge clk);
    checks++;
    if (perf_fetched !== 32'(pops) || perf_stall !== 32'(stalls)) begin
      errors++;
      $display("FAIL perf: fetched=%0d stall=%0d, required %0d %0d", perf_fetched, perf_stall, pops, stalls);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_gnt_hold();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef IFETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
